// File: rtl/tt_io_pkg.sv
// Shared definitions for the TinyTapeout pad bridge: mode encodings, the
// 7-segment hex font and the "everything off" pin patterns.
package tt_io_pkg;

    typedef enum logic [1:0] {
        MODE_LED   = 2'd0,
        MODE_SEG   = 2'd1,
        MODE_LEDIN = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG7_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] seg_off(input logic active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    // Inactive level on the anode pins; bits at or above the digit count stay 0.
    function automatic logic [7:0] an_off(input logic active_low, input int digits);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) begin
                v[i] = active_low;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble + decimal point to 7-segment byte (active-high).
module hex7seg
    import tt_io_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {dp_i, SEG7_FONT[nibble_i]};

endmodule

// File: rtl/tt_io_scan_bridge.sv
// Pad-side bridge: synchronises switch pads to the core and drives LEDs or a
// scanned multi-digit 7-segment display onto the TinyTapeout output pins.
module tt_io_scan_bridge
    import tt_io_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1024,
    parameter int BLANK_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            ui_in,
    input  logic [7:0]            uio_in,
    input  logic [1:0]            mode,
    input  logic [15:0]           led_in,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [15:0]           sw_sync,
    output logic                  sw_change,
    output logic [7:0]            uo_out,
    output logic [7:0]            uio_out,
    output logic [7:0]            uio_oe
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] AN_MASK = an_off(1'b1, DIGITS);
    localparam logic [7:0] SEG_IDLE = seg_off(ACTIVE_LOW != 0);
    localparam logic [7:0] AN_IDLE  = an_off(ACTIVE_LOW != 0, DIGITS);

    mode_e mode_q, mode_d;
    assign mode_d = mode_e'(mode);

    // ---------------- switch input path ----------------
    logic [15:0]                  raw;
    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0]                  sw_prev_q;
    logic                         sw_change_q;

    // The high pad byte is only an input while the bidirectional pins are released.
    assign raw = {(mode_q == MODE_LEDIN) ? uio_in : 8'h00, ui_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            sw_prev_q   <= '0;
            sw_change_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
            sw_prev_q   <= sync_q[SYNC_STAGES-1];
            sw_change_q <= (sync_q[SYNC_STAGES-1] != sw_prev_q);
        end
    end

    assign sw_sync   = sync_q[SYNC_STAGES-1];
    assign sw_change = sw_change_q;

    // ---------------- digit scanner ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (mode_d == MODE_SEG) begin
            if (mode_q != MODE_SEG) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    logic [7:0]        seg_all [DIGITS];
    logic [DIGITS-1:0] lz_blank;
    logic [7:0]        an_vec;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        hex7seg u_hex7seg (
            .nibble_i (hex_in[4*gi +: 4]),
            .dp_i     (dp_in[gi]),
            .seg_o    (seg_all[gi])
        );
        // A digit is a leading zero when it and every digit to its left are 0.
        if (gi == 0) begin : g_lz0
            assign lz_blank[gi] = 1'b0;
        end else begin : g_lzn
            assign lz_blank[gi] = (BLANK_LZ != 0) && (hex_in[4*DIGITS-1:4*gi] == '0);
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_anode
        if (gi < DIGITS) begin : g_used
            assign an_vec[gi] = (idx_d == IDX_W'(gi));
        end else begin : g_unused
            assign an_vec[gi] = 1'b0;
        end
    end

    // ---------------- pin outputs ----------------
    logic [7:0] uo_q, uo_d, uio_q, uio_d, oe_q, oe_d;
    logic       slot_blank;

    always_comb begin
        uo_d       = '0;
        uio_d      = '0;
        oe_d       = '0;
        slot_blank = (int'(cnt_d) < BLANK_CYC) || lz_blank[idx_d];
        case (mode_d)
            MODE_SEG: begin
                oe_d = AN_MASK;
                if (slot_blank) begin
                    uo_d  = SEG_IDLE;
                    uio_d = AN_IDLE;
                end else begin
                    uo_d  = (ACTIVE_LOW != 0) ? ~seg_all[idx_d] : seg_all[idx_d];
                    uio_d = (ACTIVE_LOW != 0) ? (an_vec ^ AN_MASK) : an_vec;
                end
            end
            MODE_LEDIN: begin
                uo_d = led_in[7:0];
            end
            default: begin
                uo_d  = led_in[7:0];
                uio_d = led_in[15:8];
                oe_d  = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_LED;
            cnt_q  <= '0;
            idx_q  <= '0;
            uo_q   <= '0;
            uio_q  <= '0;
            oe_q   <= '0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            uo_q   <= uo_d;
            uio_q  <= uio_d;
            oe_q   <= oe_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = oe_q;

endmodule

// File: tb/tb_tt_io_scan_bridge.sv
// Randomised and directed bench for tt_io_scan_bridge; three instances with
// different blanking/polarity settings share the same stimulus.
module tb_tt_io_scan_bridge;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int SS = 2;
    localparam int BC_P [3] = '{1, 1, 2};
    localparam int AL_P [3] = '{0, 0, 1};
    localparam int LZ_P [3] = '{0, 1, 1};
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [7:0] SCAN_SEG [4] = '{8'h71, 8'h5B, 8'h77, 8'h06};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ui_in = '0, uio_in = '0;
    logic [1:0]  mode = '0;
    logic [15:0] led_in = '0, hex_in = '0;
    logic [3:0]  dp_in = '0;

    logic [15:0] sw_o  [3];
    logic        chg_o [3];
    logic [7:0]  uo_o  [3];
    logic [7:0]  uio_o [3];
    logic [7:0]  oe_o  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        tt_io_scan_bridge #(
            .DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC_P[gi]), .SYNC_STAGES(SS),
            .ACTIVE_LOW(AL_P[gi]), .BLANK_LZ(LZ_P[gi])
        ) u_dut (
            .clk(clk), .rst(rst), .ui_in(ui_in), .uio_in(uio_in), .mode(mode),
            .led_in(led_in), .hex_in(hex_in), .dp_in(dp_in),
            .sw_sync(sw_o[gi]), .sw_change(chg_o[gi]),
            .uo_out(uo_o[gi]), .uio_out(uio_o[gi]), .uio_oe(oe_o[gi])
        );
    end

    // ---------------- reference model ----------------
    // Scan state is kept as elapsed cycles since the display was (re)started.
    logic [1:0]  m_mode_q;
    int          m_t;
    logic [23:0] m_exp [3];
    logic [15:0] raw_hist [$];
    logic [15:0] m_sync, m_prev;
    logic        m_change;

    function automatic int next_t(logic [1:0] md, logic [1:0] mq, int t);
        if (md != 2'd1) return t;
        return (mq == 2'd1) ? t + 1 : 0;
    endfunction

    function automatic logic [23:0] model_pins(int inst, logic [1:0] md, int t,
                                               logic [15:0] hex, logic [3:0] dp, logic [15:0] led);
        int pos, dig;
        logic [3:0] nib;
        logic [7:0] seg, an;
        bit blank;
        if (md == 2'd2) return {led[7:0], 8'h00, 8'h00};
        if (md != 2'd1) return {led[7:0], led[15:8], 8'hFF};
        pos   = t % SD;
        dig   = (t / SD) % ND;
        nib   = 4'((hex >> (4 * dig)) & 16'hF);
        blank = (pos < BC_P[inst]) || (LZ_P[inst] != 0 && dig > 0 && (hex >> (4 * dig)) == 16'h0);
        seg   = blank ? 8'h00 : {dp[dig], FONT[nib]};
        an    = blank ? 8'h00 : 8'(1 << dig);
        if (AL_P[inst] != 0) begin
            seg = ~seg;
            an  = an ^ 8'h0F;
        end
        return {seg, an, 8'h0F};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode_q <= '0;
            m_t      <= 0;
            for (int i = 0; i < 3; i++) m_exp[i] <= '0;
            raw_hist.delete();
            m_sync   <= '0;
            m_prev   <= '0;
            m_change <= 1'b0;
        end else begin
            m_mode_q <= mode;
            m_t      <= next_t(mode, m_mode_q, m_t);
            for (int i = 0; i < 3; i++)
                m_exp[i] <= model_pins(i, mode, next_t(mode, m_mode_q, m_t), hex_in, dp_in, led_in);
            raw_hist.push_back({(m_mode_q == 2'd2) ? uio_in : 8'h00, ui_in});
            m_sync   <= (raw_hist.size() >= SS) ? raw_hist[raw_hist.size() - SS] : 16'h0;
            m_prev   <= m_sync;
            m_change <= (m_sync != m_prev);
        end
    end

    function automatic int cur_pos();
        return m_t % SD;
    endfunction

    function automatic int cur_dig();
        return (m_t / SD) % ND;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; led_in = 16'hA55A;
        repeat (3) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({uo_o[i], uio_o[i], oe_o[i], sw_o[i], chg_o[i]} !== 41'h0) begin
                    errors++;
                    $display("FAIL reset[%0d]: got uo=%h uio=%h oe=%h sw=%h chg=%b, want all 0",
                             i, uo_o[i], uio_o[i], oe_o[i], sw_o[i], chg_o[i]);
                end
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (uo_o[0] !== 8'h5A || uio_o[0] !== 8'hA5 || oe_o[0] !== 8'hFF) begin
            errors++;
            $display("FAIL led_after_reset: got uo=%h uio=%h oe=%h, want 5a a5 ff",
                     uo_o[0], uio_o[0], oe_o[0]);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_led_modes();
        for (int c = 0; c < 30; c++) begin
            int r;
            r      = $urandom_range(0, 2);
            mode   = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
            led_in = 16'($urandom);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({uo_o[i], uio_o[i], oe_o[i]} !== m_exp[i] || sw_o[i] !== m_sync || chg_o[i] !== m_change) begin
                    errors++;
                    $display("FAIL led_mode[%0d] c=%0d: got %h%h%h sw=%h chg=%b, want %h sw=%h chg=%b",
                             i, c, uo_o[i], uio_o[i], oe_o[i], sw_o[i], chg_o[i], m_exp[i], m_sync, m_change);
                end
            end
        end
        $display("test_led_modes done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_switch_sync();
        int pulses;
        mode = 2'd2; ui_in = 8'h00; uio_in = 8'h00;
        repeat (4) tick();
        uio_in = 8'h12; ui_in = 8'h34;
        tick();
        checks++;
        if (sw_o[0] !== 16'h0000) begin
            errors++;
            $display("FAIL sync_early: got sw=%h, want 0000", sw_o[0]);
        end
        tick();
        checks++;
        if (sw_o[0] !== 16'h1234 || chg_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL sync_1234: got sw=%h chg=%b, want 1234 0", sw_o[0], chg_o[0]);
        end
        tick();
        checks++;
        if (chg_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL change_pulse: got chg=%b, want 1", chg_o[0]);
        end
        tick();
        checks++;
        if (chg_o[0] !== 1'b0 || sw_o[0] !== 16'h1234) begin
            errors++;
            $display("FAIL change_single: got sw=%h chg=%b, want 1234 0", sw_o[0], chg_o[0]);
        end
        mode   = 2'd0;
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(chg_o[0]);
            checks++;
            if (sw_o[0] !== m_sync || chg_o[0] !== m_change) begin
                errors++;
                $display("FAIL sync_mask: got sw=%h chg=%b, want sw=%h chg=%b", sw_o[0], chg_o[0], m_sync, m_change);
            end
        end
        checks++;
        if (pulses != 1 || sw_o[0] !== 16'h0034) begin
            errors++;
            $display("FAIL mask_upper: got sw=%h pulses=%0d, want 0034 1", sw_o[0], pulses);
        end
        $display("test_switch_sync done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_scan();
        hex_in = 16'h1A2F; dp_in = 4'h0; mode = 2'd1;
        for (int c = 0; c < 40; c++) begin
            int pos, dig;
            logic [7:0] want_uo, want_uio;
            tick();
            pos      = c % SD;
            dig      = (c / SD) % ND;
            want_uo  = (pos == 0) ? 8'h00 : SCAN_SEG[dig];
            want_uio = (pos == 0) ? 8'h00 : 8'(1 << dig);
            checks++;
            if (uo_o[0] !== want_uo || uio_o[0] !== want_uio || oe_o[0] !== 8'h0F) begin
                errors++;
                $display("FAIL scan c=%0d: got uo=%h uio=%h oe=%h, want %h %h 0f",
                         c, uo_o[0], uio_o[0], oe_o[0], want_uo, want_uio);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if ({uo_o[i], uio_o[i], oe_o[i]} !== m_exp[i]) begin
                    errors++;
                    $display("FAIL scan_model[%0d] c=%0d: got %h%h%h, want %h", i, c, uo_o[i], uio_o[i], oe_o[i], m_exp[i]);
                end
            end
        end
        $display("test_scan done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_leading_zero();
        hex_in = 16'h0050;
        for (int c = 0; c < 40; c++) begin
            logic [7:0] want_uo, want_uio;
            tick();
            want_uo = 8'h00; want_uio = 8'h00;
            if (cur_pos() >= 1 && cur_dig() == 1) begin want_uo = 8'h6D; want_uio = 8'h02; end
            if (cur_pos() >= 1 && cur_dig() == 0) begin want_uo = 8'h3F; want_uio = 8'h01; end
            checks++;
            if (uo_o[1] !== want_uo || uio_o[1] !== want_uio) begin
                errors++;
                $display("FAIL lz dig=%0d pos=%0d: got uo=%h uio=%h, want %h %h",
                         cur_dig(), cur_pos(), uo_o[1], uio_o[1], want_uo, want_uio);
            end
            checks++;
            if ({uo_o[2], uio_o[2], oe_o[2]} !== m_exp[2]) begin
                errors++;
                $display("FAIL lz_model c=%0d: got %h%h%h, want %h", c, uo_o[2], uio_o[2], oe_o[2], m_exp[2]);
            end
        end
        $display("test_leading_zero done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_active_low();
        hex_in = 16'h0008; dp_in = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            logic [7:0] want_uo, want_uio;
            tick();
            want_uo = 8'hFF; want_uio = 8'h0F;
            if (cur_pos() >= 2 && cur_dig() == 0) begin want_uo = 8'h00; want_uio = 8'h0E; end
            checks++;
            if (uo_o[2] !== want_uo || uio_o[2] !== want_uio || oe_o[2] !== 8'h0F) begin
                errors++;
                $display("FAIL active_low dig=%0d pos=%0d: got uo=%h uio=%h oe=%h, want %h %h 0f",
                         cur_dig(), cur_pos(), uo_o[2], uio_o[2], oe_o[2], want_uo, want_uio);
            end
        end
        $display("test_active_low done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_scan();
        int k;
        hex_in = 16'h1A2F; dp_in = 4'h0; mode = 2'd1;
        k = 0;
        while (k < 64 && !(cur_dig() == 2 && cur_pos() == 4)) begin
            tick();
            k++;
        end
        checks++;
        if (!(cur_dig() == 2 && cur_pos() == 4)) begin
            errors++;
            $display("FAIL mid_scan_timeout: got dig=%0d pos=%0d, want 2 4", cur_dig(), cur_pos());
        end
        checks++;
        if (uio_o[0] !== 8'h04 || uo_o[0] !== 8'h77) begin
            errors++;
            $display("FAIL before_rst: got uo=%h uio=%h, want 77 04", uo_o[0], uio_o[0]);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                rst = 1'b1;
                repeat (2) begin
                    tick();
                    checks++;
                    if ({uo_o[0], uio_o[0], oe_o[0]} !== 24'h0) begin
                        errors++;
                        $display("FAIL rst_mid_scan: got uo=%h uio=%h oe=%h, want 0", uo_o[0], uio_o[0], oe_o[0]);
                    end
                end
                rst = 1'b0;
            end else begin
                mode = 2'd0;
                repeat (3) tick();
                mode = 2'd1;
            end
            tick();
            checks++;
            if (uo_o[0] !== 8'h00 || uio_o[0] !== 8'h00 || oe_o[0] !== 8'h0F) begin
                errors++;
                $display("FAIL restart_blank pass=%0d: got uo=%h uio=%h oe=%h, want 00 00 0f",
                         pass, uo_o[0], uio_o[0], oe_o[0]);
            end
            tick();
            checks++;
            if (uo_o[0] !== 8'h71 || uio_o[0] !== 8'h01) begin
                errors++;
                $display("FAIL restart_digit0 pass=%0d: got uo=%h uio=%h, want 71 01", pass, uo_o[0], uio_o[0]);
            end
            repeat (12) tick();
        end
        $display("test_reset_mid_scan done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0)
                mode = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom_range(0, 3));
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 7) == 0)
                    hex_in[4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 3) == 0) dp_in  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) led_in = 16'($urandom);
            if ($urandom_range(0, 5) == 0) ui_in  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) uio_in = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({uo_o[i], uio_o[i], oe_o[i]} !== m_exp[i] || sw_o[i] !== m_sync || chg_o[i] !== m_change) begin
                    errors++;
                    $display("FAIL random[%0d] c=%0d: got %h%h%h sw=%h chg=%b, want %h sw=%h chg=%b",
                             i, c, uo_o[i], uio_o[i], oe_o[i], sw_o[i], chg_o[i], m_exp[i], m_sync, m_change);
                end
            end
        end
        rst = 1'b0;
        $display("test_random done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_led_modes();
        test_switch_sync();
        test_scan();
        test_leading_zero();
        test_active_low();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
